dragon_sprite_renderer: RTL and testbench
=========================================

// Module: dragon_sprite_renderer
// PURPOSE
//  Pixel-pipeline stage directly downstream of Snake_Top. Captures the seven dragon segment words
//  and Display_en once per frame on vsync, then for every active pixel decides whether a dragon
//  segment covers it and emits the pixel and its colour. Output feeds the VGA colour mux.
// PARAMETERS
//  X_OFFSET   64  left pixel edge of the 16x16 tile grid
//  Y_OFFSET   0   top pixel edge of the tile grid
//  TILE_SHIFT 5   log2 tile size in pixels (32 px tiles; sprite 8x8 scaled by 2^(TILE_SHIFT-3))
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  vsync        in   1   frame sync, asynchronous to pixel data but sampled on clk
//  Dragon_1..7  in   10  segment word: [9:8] orientation (00 up,01 right,10 down,11 left), [7:4] tile x, [3:0] tile y
//  Display_en   in   7   bit i enables Dragon_(i+1); Dragon_1 is the head
//  pix_valid    in   1   pix_x/pix_y address a visible pixel this cycle
//  pix_x        in   10  current pixel column
//  pix_y        in   10  current pixel row
//  out_valid    out  1   pix_valid delayed 3 cycles
//  dragon_pixel out  1   dragon covers the pixel issued 3 cycles earlier
//  dragon_color out  6   RRGGBB colour, 0 when dragon_pixel=0
// BEHAVIOUR
//  Reset: all outputs 0, shadow segment regs 0, shadow enable 0, vsync history 0, pipeline valids 0.
//  Frame snapshot: vsync registered twice; rising edge (sync2 & ~sync3) copies Dragon_1..7 and
//   Display_en into shadow regs on that clk. Shadows are the only source for matching; new values
//   are used from the next cycle on (lands in blanking, so no tearing). Tail index = highest set
//   bit of shadow enable; computed at snapshot and registered.
//  Stage 1: dx=pix_x-X_OFFSET, dy=pix_y-Y_OFFSET (11-bit, sign kept). in_grid = dx,dy >=0 and
//   dx>>TILE_SHIFT<16 and dy>>TILE_SHIFT<16. Register tile_x/tile_y (4b), sub_x/sub_y
//   = bits [TILE_SHIFT-1:TILE_SHIFT-3] (3b), in_grid, valid.
//  Stage 2: compare tile against 7 enabled shadows in parallel; fixed priority, lowest index wins
//   (head over body). Register hit, seg index (3b), orientation. Kind: index 0 -> HEAD; index ==
//   tail index and tail!=0 -> TAIL; else BODY. Single enabled segment -> HEAD only.
//  Stage 3: rotate (sub_x,sub_y)=(u,v) to ROM coords: 00:(u,v); 01:(v,7-u); 10:(7-u,7-v);
//   11:(7-v,u). ROM row lookup by kind+row, bit select by column. dragon_pixel = valid & in_grid
//   & hit & rom_bit. Colour HEAD 6'b110100, BODY 6'b001100, TAIL 6'b001000, else 0.
//  Latency fixed at 3 cycles, no stalls; pipeline runs every clk regardless of pix_valid.
//  Boundary: Display_en=0 -> never draws; pix out of grid or pix_valid=0 -> dragon_pixel=0;
//   duplicate tiles -> lowest index; wrap in dx/dy (negative) treated as out of grid; vsync edge
//   with no change harmless; reset mid-frame clears shadows, nothing drawn until next vsync edge.
// STRUCTURE
//  Package dragon_pkg: segment word field ranges, orientation codes, kind enum (HEAD/BODY/TAIL),
//   colour constants, grid size (16). Shared with Snake_Top.
//  Sub-module dragon_sprite_rom: combinational 3 kinds x 8 rows x 8 bit table, inputs kind,row,
//   output 8-bit row. Rest (snapshot, 3 stages, rotation) in this module.
// TESTING
//  1 Reset high 2 cycles -> all outputs 0; scan full frame before any vsync -> dragon_pixel never 1.
//  2 Dragon_1=10'b00_0000_0000, Display_en=7'b0000001, vsync pulse, scan tile(0,0) (pix 64..95,0..31)
//    -> dragon_pixel matches HEAD sprite scaled x4, colour 6'b110100, exactly 3 cycles after input.
//  3 Dragon_1=tile(3,2), Dragon_2=tile(3,2), Dragon_3=tile(4,2), en=7'b0000111 -> tile(3,2) HEAD
//    colour, tile(4,2) TAIL 6'b001000.
//  4 Change Dragon_1 to tile(5,5) mid-frame without vsync -> output still at old tile until next
//    vsync rising edge, then new tile.
//  5 Head at tile(7,7), orient 00/01/10/11 each frame -> sprite rotated per mapping; check corner
//    pixel (u=7,v=0) lands at rotated address.
//  6 pix_x=63 or 576, pix_y=512, pix_valid=0 with head covering -> dragon_pixel=0, out_valid follows.

Source files
------------

// File: rtl/dragon_pkg.sv
// dragon_pkg: segment word layout, orientation/kind codes and colours shared with Snake_Top
package dragon_pkg;
  localparam int GRID = 16;
  localparam int SEGS = 7;
  localparam int SEG_W = 10;
  localparam int ORI_HI = 9;
  localparam int ORI_LO = 8;
  localparam int TX_HI = 7;
  localparam int TX_LO = 4;
  localparam int TY_HI = 3;
  localparam int TY_LO = 0;
  typedef enum logic [1:0] {ORI_UP, ORI_RIGHT, ORI_DOWN, ORI_LEFT} orient_t;
  typedef enum logic [1:0] {HEAD, BODY, TAIL} kind_t;
  localparam logic [5:0] COL_HEAD = 6'b110100;
  localparam logic [5:0] COL_BODY = 6'b001100;
  localparam logic [5:0] COL_TAIL = 6'b001000;
  function automatic logic [2:0] top_bit(logic [SEGS-1:0] e);
    top_bit = '0;
    for (int i = 0; i < SEGS; i++) if (e[i]) top_bit = 3'(i);
  endfunction
  function automatic logic [5:0] kind_color(kind_t k);
    return k == HEAD ? COL_HEAD : k == BODY ? COL_BODY : k == TAIL ? COL_TAIL : 6'd0;
  endfunction
endpackage

// File: rtl/dragon_sprite_renderer_if.sv
// dragon_sprite_renderer_if: frame/pixel inputs and pixel outputs of the renderer
interface dragon_sprite_renderer_if;
  import dragon_pkg::*;
  logic vsync;
  logic [SEG_W-1:0] Dragon_1, Dragon_2, Dragon_3, Dragon_4, Dragon_5, Dragon_6, Dragon_7;
  logic [SEGS-1:0] Display_en;
  logic pix_valid;
  logic [9:0] pix_x, pix_y;
  logic out_valid, dragon_pixel;
  logic [5:0] dragon_color;
  modport master(output vsync, Dragon_1, Dragon_2, Dragon_3, Dragon_4, Dragon_5, Dragon_6, Dragon_7,
                 Display_en, pix_valid, pix_x, pix_y, input out_valid, dragon_pixel, dragon_color);
  modport slave(input vsync, Dragon_1, Dragon_2, Dragon_3, Dragon_4, Dragon_5, Dragon_6, Dragon_7,
                Display_en, pix_valid, pix_x, pix_y, output out_valid, dragon_pixel, dragon_color);
endinterface

// File: rtl/dragon_sprite_rom.sv
// dragon_sprite_rom: 8x8 bitmaps for head/body/tail in the up orientation, MSB is column 0
module dragon_sprite_rom
  import dragon_pkg::*;
(
  input  kind_t      kind,
  input  logic [2:0] row,
  output logic [7:0] bits
);
  localparam logic [0:7][7:0] HEAD_ROM = {8'b00011000, 8'b00111100, 8'b01111110, 8'b11011011,
                                          8'b11111111, 8'b11111111, 8'b01111110, 8'b00100100};
  localparam logic [0:7][7:0] BODY_ROM = {8'b01111110, 8'b11111111, 8'b11100111, 8'b11000011,
                                          8'b11000011, 8'b11100111, 8'b11111111, 8'b01111110};
  localparam logic [0:7][7:0] TAIL_ROM = {8'b01111110, 8'b01111110, 8'b00111100, 8'b00111100,
                                          8'b00011000, 8'b00011000, 8'b00011000, 8'b00010000};
  // row fetch for the selected segment kind
  always_comb bits = kind == HEAD ? HEAD_ROM[row] : kind == BODY ? BODY_ROM[row] :
                     kind == TAIL ? TAIL_ROM[row] : 8'h00;
endmodule

// File: rtl/dragon_sprite_renderer.sv
// dragon_sprite_renderer: per-frame segment snapshot and 3-stage dragon sprite pixel pipeline
module dragon_sprite_renderer
  import dragon_pkg::*;
#(
  parameter int X_OFFSET = 64,
  parameter int Y_OFFSET = 0,
  parameter int TILE_SHIFT = 5
) (
  input logic clk,
  input logic reset,
  dragon_sprite_renderer_if.slave bus
);
  logic [SEG_W-1:0] din [SEGS];
  logic [SEG_W-1:0] seg [SEGS];
  logic [SEGS-1:0] en;
  logic [2:0] tail, vs;
  logic [10:0] dx, dy;
  logic in_grid, unused_low;
  logic v1, g1, v2, g2, h2;
  logic [3:0] tx1, ty1;
  logic [2:0] sx1, sy1, sx2, sy2, idx, col, row;
  logic hit;
  orient_t ori, o2;
  kind_t kind, k2;
  logic [7:0] rbits;
  assign din = '{bus.Dragon_1, bus.Dragon_2, bus.Dragon_3, bus.Dragon_4, bus.Dragon_5, bus.Dragon_6,
                 bus.Dragon_7};
  // vsync synchroniser and frame snapshot on its rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      vs <= '0;
      en <= '0;
      tail <= '0;
      for (int i = 0; i < SEGS; i++) seg[i] <= '0;
    end else begin
      vs <= {vs[1:0], bus.vsync};
      if (vs[1] & ~vs[2]) begin
        seg <= din;
        en <= bus.Display_en;
        tail <= top_bit(bus.Display_en);
      end
    end
  end
  assign dx = {1'b0, bus.pix_x} - 11'(X_OFFSET);
  assign dy = {1'b0, bus.pix_y} - 11'(Y_OFFSET);
  assign in_grid = !dx[10] && !dy[10] && (dx >> TILE_SHIFT) < 11'(GRID) && (dy >> TILE_SHIFT) < 11'(GRID);
  assign unused_low = ^{dx[TILE_SHIFT-4:0], dy[TILE_SHIFT-4:0]};
  // stage 1: grid-relative tile and sub-tile sprite coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      g1 <= 1'b0;
      tx1 <= '0;
      ty1 <= '0;
      sx1 <= '0;
      sy1 <= '0;
    end else begin
      v1 <= bus.pix_valid;
      g1 <= in_grid;
      tx1 <= dx[TILE_SHIFT+3:TILE_SHIFT];
      ty1 <= dy[TILE_SHIFT+3:TILE_SHIFT];
      sx1 <= dx[TILE_SHIFT-1:TILE_SHIFT-3];
      sy1 <= dy[TILE_SHIFT-1:TILE_SHIFT-3];
    end
  end
  // tile match against all enabled segments, lowest index wins so the head stays on top
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ori = ORI_UP;
    for (int i = SEGS - 1; i >= 0; i--)
      if (en[i] && seg[i][TX_HI:TX_LO] == tx1 && seg[i][TY_HI:TY_LO] == ty1) begin
        hit = 1'b1;
        idx = 3'(i);
        ori = orient_t'(seg[i][ORI_HI:ORI_LO]);
      end
    kind = idx == 3'd0 ? HEAD : (idx == tail && tail != 3'd0) ? TAIL : BODY;
  end
  // stage 2: register match result with the sprite coordinates
  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0;
      g2 <= 1'b0;
      h2 <= 1'b0;
      k2 <= HEAD;
      o2 <= ORI_UP;
      sx2 <= '0;
      sy2 <= '0;
    end else begin
      v2 <= v1;
      g2 <= g1;
      h2 <= hit;
      k2 <= kind;
      o2 <= ori;
      sx2 <= sx1;
      sy2 <= sy1;
    end
  end
  // rotate screen-space (u,v) into up-facing ROM (column,row)
  always_comb begin
    col = o2 == ORI_UP ? sx2 : o2 == ORI_RIGHT ? sy2 : o2 == ORI_DOWN ? ~sx2 : ~sy2;
    row = o2 == ORI_UP ? sy2 : o2 == ORI_RIGHT ? ~sx2 : o2 == ORI_DOWN ? ~sy2 : sx2;
  end
  dragon_sprite_rom rom (.kind(k2), .row(row), .bits(rbits));
  // stage 3: registered pixel and colour
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.dragon_pixel <= 1'b0;
      bus.dragon_color <= '0;
    end else begin
      bus.out_valid <= v2;
      bus.dragon_pixel <= v2 & g2 & h2 & rbits[~col];
      bus.dragon_color <= (v2 & g2 & h2 & rbits[~col]) ? kind_color(k2) : 6'd0;
    end
  end
endmodule

// File: tb/tb_dragon_sprite_renderer.sv
// tb_dragon_sprite_renderer: randomized scoreboard bench with a tile/sprite reference model
module tb_dragon_sprite_renderer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dragon_sprite_renderer_if bus();
  dragon_sprite_renderer dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {int due; logic pix; logic [5:0] col;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic [9:0] m_seg [7];
  logic [6:0] m_en = '0;
  logic [9:0] nxt_seg [7];
  logic [6:0] nxt_en = '0;
  logic [7:0] spr [3][8] = '{
    '{8'b00011000, 8'b00111100, 8'b01111110, 8'b11011011, 8'b11111111, 8'b11111111, 8'b01111110, 8'b00100100},
    '{8'b01111110, 8'b11111111, 8'b11100111, 8'b11000011, 8'b11000011, 8'b11100111, 8'b11111111, 8'b01111110},
    '{8'b01111110, 8'b01111110, 8'b00111100, 8'b00111100, 8'b00011000, 8'b00011000, 8'b00011000, 8'b00010000}};
  logic [5:0] colors [3] = '{6'b110100, 6'b001100, 6'b001000};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
  endtask
  function automatic void model(int x, int y, output logic p, output logic [5:0] c);
    int dx, dy, tx, ty, u, v, tl, cc, rr, k;
    logic [7:0] b;
    dx = x - 64;
    dy = y;
    p = 1'b0;
    c = 6'd0;
    if (dx < 0 || dy < 0 || dx >= 512 || dy >= 512) return;
    tx = dx / 32;
    ty = dy / 32;
    u = (dx % 32) / 4;
    v = (dy % 32) / 4;
    tl = 0;
    for (int i = 0; i < 7; i++) if (m_en[i]) tl = i;
    for (int i = 0; i < 7; i++)
      if (m_en[i] && int'(m_seg[i][7:4]) == tx && int'(m_seg[i][3:0]) == ty) begin
        case (m_seg[i][9:8])
          2'd0: begin cc = u; rr = v; end
          2'd1: begin cc = v; rr = 7 - u; end
          2'd2: begin cc = 7 - u; rr = 7 - v; end
          default: begin cc = 7 - v; rr = u; end
        endcase
        k = i == 0 ? 0 : (i == tl) ? 2 : 1;
        b = spr[k][rr];
        p = b[7 - cc];
        c = p ? colors[k] : 6'd0;
        return;
      end
  endfunction
  task automatic issue(int x, int y, logic val);
    logic p;
    logic [5:0] c;
    @(posedge clk);
    #1;
    bus.pix_x = 10'(x);
    bus.pix_y = 10'(y);
    bus.pix_valid = val;
    if (val) begin
      model(x, y, p, c);
      q.push_back('{cyc + 3, p, c});
    end
  endtask
  task automatic idle(int n);
    repeat (n) issue(0, 0, 1'b0);
  endtask
  task automatic apply();
    {bus.Dragon_1, bus.Dragon_2, bus.Dragon_3, bus.Dragon_4} = {nxt_seg[0], nxt_seg[1], nxt_seg[2], nxt_seg[3]};
    {bus.Dragon_5, bus.Dragon_6, bus.Dragon_7} = {nxt_seg[4], nxt_seg[5], nxt_seg[6]};
    bus.Display_en = nxt_en;
  endtask
  task automatic vs_pulse();
    idle(4);
    bus.vsync = 1'b1;
    idle(3);
    bus.vsync = 1'b0;
    idle(6);
    m_seg = nxt_seg;
    m_en = nxt_en;
  endtask
  task automatic scan_tile(int tx, int ty, int step);
    for (int yy = 0; yy < 32; yy += step)
      for (int xx = 0; xx < 32; xx += step) issue(64 + tx * 32 + xx, ty * 32 + yy, 1'b1);
  endtask
  task automatic clear_next();
    for (int i = 0; i < 7; i++) nxt_seg[i] = '0;
    nxt_en = '0;
  endtask
  // scoreboard monitor: pops on out_valid and checks exact 3-cycle timing
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      chk("missing_out_valid", 32'(q[0].due), 32'(cyc));
      void'(q.pop_front());
    end
    if (bus.out_valid === 1'b1) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("dragon_pixel", 32'(bus.dragon_pixel), 32'(e.pix));
        chk("dragon_color", 32'(bus.dragon_color), 32'(e.col));
      end else chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
    end else begin
      chk("out_valid_low", 32'(bus.out_valid), 32'd0);
      chk("idle_pixel", {25'd0, bus.dragon_pixel, bus.dragon_color}, 32'd0);
    end
  end
  initial begin
    bus.vsync = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_x = '0;
    bus.pix_y = '0;
    clear_next();
    for (int i = 0; i < 7; i++) m_seg[i] = '0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_pixel", 32'(bus.dragon_pixel), 32'd0);
    chk("reset_color", 32'(bus.dragon_color), 32'd0);
    reset = 1'b0;
    for (int y = 0; y < 480; y += 8)
      for (int x = 0; x < 640; x += 8) issue(x, y, 1'b1);
    nxt_seg[0] = 10'b00_0000_0000;
    nxt_en = 7'b0000001;
    apply();
    vs_pulse();
    scan_tile(0, 0, 1);
    nxt_seg[0] = {2'b00, 4'd3, 4'd2};
    nxt_seg[1] = {2'b01, 4'd3, 4'd2};
    nxt_seg[2] = {2'b00, 4'd4, 4'd2};
    nxt_en = 7'b0000111;
    apply();
    vs_pulse();
    scan_tile(3, 2, 2);
    scan_tile(4, 2, 2);
    nxt_seg[0] = {2'b00, 4'd5, 4'd5};
    apply();
    scan_tile(3, 2, 4);
    scan_tile(5, 5, 4);
    vs_pulse();
    scan_tile(3, 2, 4);
    scan_tile(5, 5, 4);
    clear_next();
    for (int o = 0; o < 4; o++) begin
      nxt_seg[0] = {2'(o), 4'd7, 4'd7};
      nxt_en = 7'b0000001;
      apply();
      vs_pulse();
      scan_tile(7, 7, 2);
      issue(64 + 7 * 32 + 28, 7 * 32, 1'b1);
    end
    nxt_seg[0] = {2'b00, 4'd0, 4'd0};
    apply();
    vs_pulse();
    issue(63, 5, 1'b1);
    issue(576, 5, 1'b1);
    issue(70, 512, 1'b1);
    issue(80, 8, 1'b0);
    issue(80, 8, 1'b1);
    issue(1023, 1023, 1'b1);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 7; i++) nxt_seg[i] = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      nxt_en = 7'($urandom);
      apply();
      vs_pulse();
      for (int n = 0; n < 1500; n++) issue($urandom_range(40, 215), $urandom_range(0, 135), $urandom_range(0, 3) != 0);
    end
    idle(5);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_en = '0;
    for (int i = 0; i < 7; i++) m_seg[i] = '0;
    for (int n = 0; n < 400; n++) issue($urandom_range(40, 215), $urandom_range(0, 135), 1'b1);
    vs_pulse();
    for (int n = 0; n < 800; n++) issue($urandom_range(40, 215), $urandom_range(0, 135), 1'b1);
    idle(8);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
